// File: rtl/sobel_ci_pkg.sv
// Shared definitions for the Sobel window custom instruction: op codes,
// FSM states, result bit positions and the per-row Sobel weights.
package sobel_ci_pkg;

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_PUSH   = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_THRESH = 2'b11;

  localparam int unsigned EDGE_BIT  = 32'd31;
  localparam int unsigned VALID_BIT = 32'd30;
  localparam int unsigned ERR_BIT   = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_ACC  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Horizontal-gradient weight of row r: {1,2,1}.
  function automatic logic signed [2:0] wx(input logic [1:0] r);
    logic signed [2:0] w;
    case (r)
      2'd0:    w = 3'sd1;
      2'd1:    w = 3'sd2;
      2'd2:    w = 3'sd1;
      default: w = 3'sd0;
    endcase
    return w;
  endfunction

  // Vertical-gradient weight of row r: {-1,0,+1}.
  function automatic logic signed [2:0] wy(input logic [1:0] r);
    logic signed [2:0] w;
    case (r)
      2'd0:    w = -3'sd1;
      2'd1:    w = 3'sd0;
      2'd2:    w = 3'sd1;
      default: w = 3'sd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sobel_row_term.sv
// Registered first stage of a row push: weighted row contributions tx/ty
// for the current row index, captured when en_i is high.
module sobel_row_term
  import sobel_ci_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 32'd8
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          en_i,
  input  logic [PIXEL_WIDTH-1:0]        p0_i,
  input  logic [PIXEL_WIDTH-1:0]        p1_i,
  input  logic [PIXEL_WIDTH-1:0]        p2_i,
  input  logic [1:0]                    r_i,
  output logic signed [PIXEL_WIDTH+3:0] tx_o,
  output logic signed [PIXEL_WIDTH+3:0] ty_o
);

  localparam int unsigned ACC_W = PIXEL_WIDTH + 32'd4;

  logic signed [ACC_W-1:0] p0_s, p1_s, p2_s;
  logic signed [ACC_W-1:0] diff_s, sum_s;
  logic signed [2:0]       wx3_s, wy3_s;
  logic signed [ACC_W-1:0] wx_s, wy_s;
  logic signed [ACC_W-1:0] tx_d, ty_d, tx_q, ty_q;

  // Zero-extended pixels, then sign-extended weights, combined into the row terms.
  always_comb begin
    p0_s   = $signed({4'b0000, p0_i});
    p1_s   = $signed({4'b0000, p1_i});
    p2_s   = $signed({4'b0000, p2_i});
    wx3_s  = wx(r_i);
    wy3_s  = wy(r_i);
    wx_s   = {{(ACC_W-3){wx3_s[2]}}, wx3_s};
    wy_s   = {{(ACC_W-3){wy3_s[2]}}, wy3_s};
    diff_s = p2_s - p0_s;
    sum_s  = p0_s + {p1_s[ACC_W-2:0], 1'b0} + p2_s;
    tx_d   = diff_s * wx_s;
    ty_d   = sum_s * wy_s;
  end

  // Stage register for the row terms.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      tx_q <= '0;
      ty_q <= '0;
    end else if (en_i) begin
      tx_q <= tx_d;
      ty_q <= ty_d;
    end
  end

  assign tx_o = tx_q;
  assign ty_o = ty_q;

endmodule

// File: rtl/sobel_window_ci.sv
// Sobel 3x3 window custom instruction: accumulates Gx/Gy row by row and
// reports |Gx|+|Gy| with a threshold edge flag. result is zero unless done.
module sobel_window_ci
  import sobel_ci_pkg::*;
#(
  parameter logic [7:0]  customId       = 8'h18,
  parameter int unsigned PIXEL_WIDTH    = 32'd8,
  parameter int unsigned THRESH_DEFAULT = 32'd256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned PW    = PIXEL_WIDTH;
  localparam int unsigned ACC_W = PW + 32'd4;
  localparam int unsigned MAG_W = PW + 32'd3;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] gx_q, gx_d, gy_q, gy_d;
  logic signed [ACC_W-1:0] tx_s, ty_s;
  logic [1:0]              row_cnt_q, row_cnt_d;
  logic [MAG_W-1:0]        thresh_q, thresh_d;
  logic [3*PW-1:0]         pix_q, pix_d;
  logic                    done_q, done_d;
  logic [31:0]             result_q, result_d;

  logic             accept_s, full_s, row_en_s;
  logic [1:0]       op_s;
  logic [ACC_W-1:0] ax_s, ay_s;
  logic [MAG_W-1:0] mag_s;
  logic             valid_s, edge_s;
  logic [31:0]      read_res_s;
  logic             unused_bits_s;

  assign op_s          = valueB[1:0];
  assign accept_s      = start && (ciN == customId) && (state_q == ST_IDLE);
  assign full_s        = (row_cnt_q == 2'd3);
  assign row_en_s      = (state_q == ST_ROW);
  assign unused_bits_s = ^{valueB[31:2], valueA[31:3*PW]};

  sobel_row_term #(
    .PIXEL_WIDTH(PW)
  ) u_row_term (
    .clock_i (clock),
    .reset_i (reset),
    .en_i    (row_en_s),
    .p0_i    (pix_q[PW-1:0]),
    .p1_i    (pix_q[2*PW-1:PW]),
    .p2_i    (pix_q[3*PW-1:2*PW]),
    .r_i     (row_cnt_q),
    .tx_o    (tx_s),
    .ty_o    (ty_s)
  );

  // READ response; the magnitude cannot overflow MAG_W since |Gx|,|Gy| <= 4*(2^PW-1).
  always_comb begin
    ax_s       = gx_q[ACC_W-1] ? -gx_q : gx_q;
    ay_s       = gy_q[ACC_W-1] ? -gy_q : gy_q;
    mag_s      = MAG_W'(ax_s + ay_s);
    valid_s    = full_s;
    edge_s     = (mag_s >= thresh_q);
    read_res_s = 32'd0;
    if (valid_s) begin
      read_res_s[EDGE_BIT]  = edge_s;
      read_res_s[VALID_BIT] = 1'b1;
      read_res_s[MAG_W-1:0] = mag_s;
    end else begin
      read_res_s = 32'd0;
    end
  end

  // FSM next state, accumulator updates and the one-cycle response.
  always_comb begin
    state_d   = state_q;
    gx_d      = gx_q;
    gy_d      = gy_q;
    row_cnt_d = row_cnt_q;
    thresh_d  = thresh_q;
    pix_d     = pix_q;
    done_d    = 1'b0;
    result_d  = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (op_s)
            OP_CLEAR: begin
              gx_d      = '0;
              gy_d      = '0;
              row_cnt_d = 2'd0;
              state_d   = ST_RESP;
              done_d    = 1'b1;
            end
            OP_PUSH: begin
              if (full_s) begin
                result_d[ERR_BIT] = 1'b1;
                state_d           = ST_RESP;
                done_d            = 1'b1;
              end else begin
                pix_d   = valueA[3*PW-1:0];
                state_d = ST_ROW;
              end
            end
            OP_READ: begin
              result_d = read_res_s;
              state_d  = ST_RESP;
              done_d   = 1'b1;
              if (valueA[0]) begin
                gx_d      = '0;
                gy_d      = '0;
                row_cnt_d = 2'd0;
              end else begin
                row_cnt_d = row_cnt_q;
              end
            end
            OP_THRESH: begin
              thresh_d = valueA[MAG_W-1:0];
              state_d  = ST_RESP;
              done_d   = 1'b1;
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ROW: state_d = ST_ACC;
      ST_ACC: begin
        gx_d      = gx_q + tx_s;
        gy_d      = gy_q + ty_s;
        row_cnt_d = row_cnt_q + 2'd1;
        state_d   = ST_RESP;
        done_d    = 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gx_q      <= '0;
      gy_q      <= '0;
      row_cnt_q <= 2'd0;
      thresh_q  <= MAG_W'(THRESH_DEFAULT);
      pix_q     <= '0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      row_cnt_q <= row_cnt_d;
      thresh_q  <= thresh_d;
      pix_q     <= pix_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_sobel_window_ci.sv
// Bench for sobel_window_ci: a window-level model predicts every done pulse
// and result; literal expectations pin the model on the key windows.
module tb_sobel_window_ci;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  sobel_window_ci dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .ciN    (ciN),
    .valueA (valueA),
    .valueB (valueB),
    .done   (done),
    .result (result)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [31:0] res;
  } exp_t;

  exp_t        expq[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          checking = 1'b0;
  logic [31:0] cap;

  int mgx, mgy, mrows, mthr, last_done;
  int wxa[3] = '{1, 2, 1};
  int wya[3] = '{-1, 0, 1};

  always @(posedge clock) cyc <= cyc + 1;

  // Every cycle: done/result must match the model's pending pulse (or be idle).
  always @(negedge clock) begin
    logic        hit;
    logic [31:0] er;
    if (checking) begin
      hit = (expq.size() > 0) && (expq[0].cyc == cyc);
      er  = hit ? expq[0].res : 32'd0;
      if (hit) void'(expq.pop_front());
      checks++;
      if (done !== hit || result !== er) begin
        errors++;
        $display("FAIL cycle_cmp cyc=%0d done=%b result=%h expected done=%b result=%h",
                 cyc, done, result, hit, er);
      end
      if (done === 1'b1) cap = result;
    end
  end

  task automatic model_reset();
    mgx = 0; mgy = 0; mrows = 0; mthr = 256;
    expq.delete();
    last_done = cyc;
  endtask

  task automatic model_step(input logic [7:0] ci, input logic [1:0] op,
                            input logic [31:0] a, input int c);
    int lat, p0, p1, p2, mag;
    logic [31:0] res;
    if (ci != 8'h18 || c <= last_done) return;
    lat = 1;
    res = 32'd0;
    case (op)
      2'b00: begin mgx = 0; mgy = 0; mrows = 0; end
      2'b01: begin
        if (mrows == 3) res = 32'd1;
        else begin
          p0 = int'(a[7:0]); p1 = int'(a[15:8]); p2 = int'(a[23:16]);
          mgx += wxa[mrows] * (p2 - p0);
          mgy += wya[mrows] * (p0 + 2 * p1 + p2);
          mrows++;
          lat = 3;
        end
      end
      2'b10: begin
        mag = (mgx < 0 ? -mgx : mgx) + (mgy < 0 ? -mgy : mgy);
        if (mrows == 3)
          res = (mag >= mthr ? 32'h8000_0000 : 32'd0) | 32'h4000_0000 | 32'(mag);
        if (a[0]) begin mgx = 0; mgy = 0; mrows = 0; end
      end
      default: mthr = int'(a[10:0]);
    endcase
    last_done = c + lat;
    expq.push_back('{c + lat, res});
  endtask

  // Called just after a negedge; start is high for exactly one rising edge.
  task automatic issue(input logic [7:0] ci, input logic [1:0] op,
                       input logic [31:0] a, input bit model_en);
    start  = 1'b1;
    ciN    = ci;
    valueA = a;
    valueB = {30'h1555_5555, op};
    if (model_en) model_step(ci, op, a, cyc);
    @(negedge clock);
    start  = 1'b0;
    ciN    = 8'h00;
    valueA = 32'd0;
    valueB = 32'd0;
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a);
    issue(8'h18, op, a, 1'b1);
    repeat (4) @(negedge clock);
  endtask

  task automatic pin(input string name, input logic [31:0] exp);
    checks++;
    if (cap !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, cap, exp);
    end
  endtask

  function automatic logic [31:0] px(input logic [7:0] p0, input logic [7:0] p1,
                                     input logic [7:0] p2);
    return {8'hEE, p2, p1, p0};
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; ciN = 8'h00; valueA = 32'd0; valueB = 32'd0;
    cap = 32'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_reset();
    checking = 1'b1;
    repeat (2) @(negedge clock);

    // Vertical edge: mag 1020 against default threshold 256.
    run(2'b00, 32'd0);
    for (int i = 0; i < 3; i++) run(2'b01, px(8'd0, 8'd0, 8'd255));
    cap = 32'hA5A5_A5A5; run(2'b10, 32'd0);
    pin("read_vertical_edge", 32'hC000_03FC);

    // Flat window.
    run(2'b00, 32'd0);
    for (int i = 0; i < 3; i++) run(2'b01, px(8'd100, 8'd100, 8'd100));
    cap = 32'hA5A5_A5A5; run(2'b10, 32'd0);
    pin("read_flat", 32'h4000_0000);

    // Auto-clear on a partial window, then a fresh full window.
    run(2'b00, 32'd0);
    for (int i = 0; i < 2; i++) run(2'b01, px(8'd9, 8'd50, 8'd200));
    cap = 32'hA5A5_A5A5; run(2'b10, 32'd1);
    pin("read_partial_autoclear", 32'd0);
    cap = 32'hA5A5_A5A5; run(2'b10, 32'd0);
    pin("read_after_autoclear", 32'd0);
    for (int i = 0; i < 3; i++) run(2'b01, px(8'd0, 8'd0, 8'd255));
    cap = 32'hA5A5_A5A5; run(2'b10, 32'd0);
    pin("read_after_refill", 32'hC000_03FC);

    // Foreign CI number is ignored.
    cap = 32'hA5A5_A5A5;
    issue(8'h19, 2'b00, 32'd0, 1'b1);
    repeat (4) @(negedge clock);
    pin("foreign_ciN", 32'hA5A5_A5A5);

    // Starts while busy and coincident with done are ignored.
    run(2'b00, 32'd0);
    issue(8'h18, 2'b01, px(8'd0, 8'd0, 8'd255), 1'b1);
    for (int i = 0; i < 3; i++) issue(8'h18, 2'b00, 32'd0, 1'b1);
    repeat (4) @(negedge clock);
    for (int i = 0; i < 2; i++) run(2'b01, px(8'd0, 8'd0, 8'd255));
    cap = 32'hA5A5_A5A5; run(2'b10, 32'd0);
    pin("busy_starts_ignored", 32'hC000_03FC);

    // Threshold boundary: mag 1020 vs 1021 and 1020.
    run(2'b00, 32'd0);
    run(2'b01, px(8'd0, 8'd0, 8'd0));
    run(2'b01, px(8'd7, 8'd7, 8'd7));
    run(2'b01, px(8'd255, 8'd255, 8'd255));
    run(2'b11, 32'd1021);
    cap = 32'hA5A5_A5A5; run(2'b10, 32'd0);
    pin("thresh_1021", 32'h4000_03FC);
    run(2'b11, 32'd1020);
    cap = 32'hA5A5_A5A5; run(2'b10, 32'd0);
    pin("thresh_1020", 32'hC000_03FC);

    // Fourth push overflows; window keeps the three-row value.
    run(2'b00, 32'd0);
    for (int i = 0; i < 3; i++) run(2'b01, px(8'd0, 8'd0, 8'd255));
    cap = 32'hA5A5_A5A5; run(2'b01, px(8'd1, 8'd2, 8'd3));
    pin("push_overflow", 32'd1);
    cap = 32'hA5A5_A5A5; run(2'b10, 32'd0);
    pin("read_after_overflow", 32'hC000_03FC);

    // Reset during ROW: no pulse, threshold back to default, aborted row lost.
    run(2'b11, 32'd1021);
    run(2'b00, 32'd0);
    run(2'b01, px(8'd200, 8'd0, 8'd0));
    cap = 32'hA5A5_A5A5;
    issue(8'h18, 2'b01, px(8'd255, 8'd0, 8'd0), 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    repeat (4) @(negedge clock);
    pin("no_pulse_after_abort", 32'hA5A5_A5A5);
    for (int i = 0; i < 3; i++) run(2'b01, px(8'd0, 8'd0, 8'd255));
    cap = 32'hA5A5_A5A5; run(2'b10, 32'd0);
    pin("read_after_reset", 32'hC000_03FC);

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL pending_pulses got %0d expected 0", expq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
